plic_gateway_arb: RTL and testbench
===================================

Name: plic_gateway_arb

Overview:
- PLIC core, directly upstream/downstream of the interrupt register file.
- Per-source gateways synchronise external interrupt lines and issue one gate pulse per interrupt, which sets that source's IP bit in the register file.
- Gateways then block the source until software claims and completes it.
- A registered arbiter selects the highest-priority enabled pending source above threshold, drives final_id back to the claim register, and drives machine external interrupt (meip) to the core.

Parameters:
- EXT_IRQ_NUM, 31: index of the highest source. Source 0 is reserved, never pends and is never selected.
- PRIO_WIDTH, 3: priority bit width. Priority 0 means never interrupt.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- ext_irq  in  EXT_IRQ_NUM+1  raw asynchronous interrupt lines; bit 0 ignored
- ip_r  in  EXT_IRQ_NUM+1  pending bits from the register file
- ie_r  in  EXT_IRQ_NUM+1  enable bits from the register file
- prio_r_1d  in  PRIO_WIDTH*(EXT_IRQ_NUM+1)  packed priorities; source i occupies bits [i*PRIO_WIDTH +: PRIO_WIDTH]
- threshold_r  in  PRIO_WIDTH  target-0 threshold
- claim_id  in  8  one-cycle claim pulse carrying the id; 0 when idle
- cmplt_id  in  8  level value of the complete register
- plic_reg_gate  out  EXT_IRQ_NUM+1  one-cycle pulse that sets ip[i]
- final_id  out  8  winning source id; 0 = none
- meip  out  1  machine external interrupt request

Behaviour:
- Reset: all gateways go to OPEN, synchronisers clear, plic_reg_gate=0, final_id=0, meip=0, cmplt_q=0.
- Synchroniser: two flops per ext_irq bit; irq_s is the second stage.
- Gateway states per source i≥1:
  - OPEN: if irq_s[i]=1, pulse plic_reg_gate[i] for exactly 1 cycle, then go to PEND.
  - PEND: on claim_id==i, go to CLAIMED.
  - CLAIMED: on cmpl_evt[i], go to OPEN.
- Completion event: cmpl_evt[i] = (cmplt_id != cmplt_q) && (cmplt_id == i). cmplt_q registers cmplt_id every cycle.
  - Repeating a completion of the same id requires an intervening write of another value; firmware writes the id, then 0.
  - cmplt_id values of 0 or above EXT_IRQ_NUM are ignored.
- Claim and completion in the same cycle for a PEND source: the claim wins. The source goes to CLAIMED; the completion is not lost if cmplt_q still differs on the next cycle, otherwise software repeats it.
- Completion for a source not in CLAIMED: ignored.
- A level still high on re-entry to OPEN re-gates after 1 cycle.
- Latency:
  - ext_irq edge to gate pulse: 3 cycles (2 synchroniser cycles plus 1 state register).
  - ip_r/ie_r/prio/threshold change to final_id/meip update: 1 cycle (registered arbiter).
- Arbiter:
  - Candidate i: i≥1, ip_r[i] & ie_r[i], prio_i > threshold_r (unsigned).
  - Winner: maximum priority; ties go to the lowest id.
  - No candidate: final_id=0.
  - meip = registered (next final_id != 0).
- Bit 0 of plic_reg_gate is tied to 0.
- Asynchronous reset mid-operation returns every gateway to OPEN. Sources still asserted re-gate 3 cycles after rstn deasserts.

Optional Feature:
- Macro: PLIC_EDGE_TRIG_EN.
- Defined:
  - Adds input src_edge [EXT_IRQ_NUM:0]; bit i=1 makes source i edge-triggered.
  - Edge sources gate on a rising edge of irq_s; a third flop holds the previous value.
  - A rising edge seen in PEND or CLAIMED sets a 1-bit latched flag. On return to OPEN the flag produces a gate pulse the next cycle and clears.
  - Further edges while the flag is set are merged.
- Undefined: the port is absent and all sources are level-triggered with no latch flag.

Decomposition:
- plic_pkg holds:
  - gw_state_t enum: OPEN=2'd0, PEND=2'd1, CLAIMED=2'd2
  - ID_W=8
  - RESERVED_ID=0
- Sub-module plic_gateway (one instance per source, generate loop) holds the synchroniser, state, edge latch and gate pulse. The arbiter stays in the top module.

Test Plan:
- Level on source 5, prio5=3, ie5=1, threshold=1: gate[5] pulses once at cycle+3; with ip_r[5] fed back, final_id=5 and meip=1 one cycle later. Holding ext_irq high gives no second gate.
- Full handshake: claim_id=5 pulse, then cmplt_id 0→5 with the line still high: gate[5] pulses again 1 cycle after the completion. Writing cmplt 5 then 5 again (no change) gives no reopen.
- Priority tie: sources 3 and 7 pending, both prio=4 → final_id=3. Raise prio7 to 6 → final_id=7 the next cycle. Set threshold=6 → final_id=0 and meip=0.
- Source with prio=0, or ie=0, or pending source 0: never selected; final_id stays 0.
- Claim and completion same cycle: cmplt_id changes to 9 in the same cycle as claim_id=9 pulses → gateway 9 ends in CLAIMED; the next cmplt change to 9 (after a 0 write) reopens it.
- PLIC_EDGE_TRIG_EN with src_edge[4]=1: two pulses on ext_irq[4] while CLAIMED → exactly one gate[4] pulse 1 cycle after completion. Reset asserted mid-PEND → gateways OPEN, final_id=0, meip=0.

Source files
------------

// File: rtl/plic_pkg.sv
// Shared types and constants for the PLIC gateway/arbiter slice.
package plic_pkg;

    localparam int ID_W        = 8;
    localparam int RESERVED_ID = 0;

    typedef enum logic [1:0] {
        OPEN    = 2'd0,
        PEND    = 2'd1,
        CLAIMED = 2'd2
    } gw_state_t;

endpackage

// File: rtl/plic_gateway.sv
// Per-source interrupt gateway: 2-flop synchroniser, OPEN/PEND/CLAIMED state, gate pulse.
// PLIC_EDGE_TRIG_EN adds per-source edge triggering with a one-deep latched edge flag.
module plic_gateway
    import plic_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic irq,
    input  logic claim,
    input  logic cmpl_evt,
`ifdef PLIC_EDGE_TRIG_EN
    input  logic edge_mode,
`endif
    output logic gate
);

    logic      irq_m;
    logic      irq_s;
    logic      trigger;
    gw_state_t state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_m <= 1'b0;
            irq_s <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each stage sample the previous stage's old value.
            irq_m <= irq;
            irq_s <= irq_m;
        end
    end

`ifdef PLIC_EDGE_TRIG_EN
    logic irq_d;
    logic rise;
    logic edge_flag;

    assign rise    = irq_s & ~irq_d;
    assign trigger = edge_mode ? (rise | edge_flag) : irq_s;

    // Edges arriving while blocked are merged into one deferred request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_d     <= 1'b0;
            edge_flag <= 1'b0;
        end else begin
            irq_d <= irq_s;
            if (state != OPEN) begin
                if (edge_mode && rise)
                    edge_flag <= 1'b1;
            end else begin
                edge_flag <= 1'b0;
            end
        end
    end
`else
    assign trigger = irq_s;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= OPEN;
            gate  <= 1'b0;
        end else begin
            gate <= 1'b0;
            case (state)
                OPEN: begin
                    if (trigger) begin
                        gate  <= 1'b1;
                        state <= PEND;
                    end
                end
                PEND:    if (claim)    state <= CLAIMED;
                CLAIMED: if (cmpl_evt) state <= OPEN;
                default: state <= OPEN;
            endcase
        end
    end

endmodule

// File: rtl/plic_gateway_arb.sv
// PLIC gateways for sources 1..EXT_IRQ_NUM plus registered max-priority arbiter driving final_id/meip.
// Optional macro PLIC_EDGE_TRIG_EN adds the src_edge port for edge-triggered sources.
module plic_gateway_arb
    import plic_pkg::*;
#(
    parameter int EXT_IRQ_NUM = 31,
    parameter int PRIO_WIDTH  = 3
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic [EXT_IRQ_NUM:0]                  ext_irq,
    input  logic [EXT_IRQ_NUM:0]                  ip_r,
    input  logic [EXT_IRQ_NUM:0]                  ie_r,
    input  logic [PRIO_WIDTH*(EXT_IRQ_NUM+1)-1:0] prio_r_1d,
    input  logic [PRIO_WIDTH-1:0]                 threshold_r,
    input  logic [ID_W-1:0]                       claim_id,
    input  logic [ID_W-1:0]                       cmplt_id,
`ifdef PLIC_EDGE_TRIG_EN
    input  logic [EXT_IRQ_NUM:0]                  src_edge,
`endif
    output logic [EXT_IRQ_NUM:0]                  plic_reg_gate,
    output logic [ID_W-1:0]                       final_id,
    output logic                                  meip
);

    logic [ID_W-1:0]       cmplt_q;
    logic                  cmpl_chg;
    logic [ID_W-1:0]       win_id;
    logic [PRIO_WIDTH-1:0] win_prio;
    logic [PRIO_WIDTH-1:0] cur_prio;
    logic                  unused_src0;

    // Source 0 is reserved; its inputs are deliberately dropped.
`ifdef PLIC_EDGE_TRIG_EN
    assign unused_src0 = ^{ext_irq[0], ip_r[0], ie_r[0], prio_r_1d[PRIO_WIDTH-1:0], src_edge[0]};
`else
    assign unused_src0 = ^{ext_irq[0], ip_r[0], ie_r[0], prio_r_1d[PRIO_WIDTH-1:0]};
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cmplt_q <= '0;
        else       cmplt_q <= cmplt_id;
    end

    // A completion is a change of the complete register, so a held value fires once.
    assign cmpl_chg         = (cmplt_id != cmplt_q);
    assign plic_reg_gate[0] = 1'b0;

    for (genvar i = 1; i <= EXT_IRQ_NUM; i++) begin : g_gw
        plic_gateway u_gw (
            .clk      (clk),
            .rstn     (rstn),
            .irq      (ext_irq[i]),
            .claim    (claim_id == ID_W'(i)),
            .cmpl_evt (cmpl_chg && (cmplt_id == ID_W'(i))),
`ifdef PLIC_EDGE_TRIG_EN
            .edge_mode(src_edge[i]),
`endif
            .gate     (plic_reg_gate[i])
        );
    end

    // Ascending scan with strict '>' keeps the lowest id on priority ties.
    always_comb begin
        // NOTE: defaults first so every path assigns every variable and no latch is inferred.
        win_id   = ID_W'(RESERVED_ID);
        win_prio = '0;
        cur_prio = '0;
        for (int i = 1; i <= EXT_IRQ_NUM; i++) begin
            cur_prio = prio_r_1d[i*PRIO_WIDTH +: PRIO_WIDTH];
            if (ip_r[i] && ie_r[i] && (cur_prio > threshold_r) && (cur_prio > win_prio)) begin
                win_id   = ID_W'(i);
                win_prio = cur_prio;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            final_id <= '0;
            meip     <= 1'b0;
        end else begin
            final_id <= win_id;
            meip     <= (win_id != ID_W'(RESERVED_ID));
        end
    end

endmodule

// File: tb/tb_plic_gateway_arb.sv
// Directed bench for plic_gateway_arb: arbiter vector table plus gateway handshake sequences.
module tb_plic_gateway_arb;
    import plic_pkg::*;

    localparam int N  = 31;
    localparam int PW = 3;
    localparam int W  = N + 1;

    logic             clk = 1'b0;
    logic             rstn;
    logic [N:0]       ext_irq, ip_r, ie_r, plic_reg_gate;
    logic [PW*W-1:0]  prio_r_1d;
    logic [PW-1:0]    threshold_r;
    logic [7:0]       claim_id, cmplt_id, final_id;
    logic             meip;
    logic [N:0]       acc;
`ifdef PLIC_EDGE_TRIG_EN
    logic [N:0]       src_edge;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    plic_gateway_arb #(.EXT_IRQ_NUM(N), .PRIO_WIDTH(PW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .ext_irq      (ext_irq),
        .ip_r         (ip_r),
        .ie_r         (ie_r),
        .prio_r_1d    (prio_r_1d),
        .threshold_r  (threshold_r),
        .claim_id     (claim_id),
        .cmplt_id     (cmplt_id),
`ifdef PLIC_EDGE_TRIG_EN
        .src_edge     (src_edge),
`endif
        .plic_reg_gate(plic_reg_gate),
        .final_id     (final_id),
        .meip         (meip)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [N:0]      ip;
        logic [N:0]      ie;
        logic [PW*W-1:0] prio;
        logic [PW-1:0]   thr;
        logic [7:0]      exp_id;
        logic            exp_meip;
    } arb_vec_t;

    arb_vec_t vq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance n cycles, OR-ing every gate vector seen into acc.
    task automatic tick_acc(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            acc = acc | plic_reg_gate;
        end
    endtask

    function automatic logic [N:0] bit_of(input int id);
        logic [N:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    function automatic logic [PW*W-1:0] prio_of(input int id, input logic [PW-1:0] p);
        logic [PW*W-1:0] v;
        v             = '0;
        v[id*PW +: PW] = p;
        return v;
    endfunction

    task automatic add_vec(input string name, input logic [N:0] ip, input logic [N:0] ie,
                           input logic [PW*W-1:0] prio, input logic [PW-1:0] thr,
                           input logic [7:0] exp_id, input logic exp_meip);
        arb_vec_t v;
        v.name     = name;
        v.ip       = ip;
        v.ie       = ie;
        v.prio     = prio;
        v.thr      = thr;
        v.exp_id   = exp_id;
        v.exp_meip = exp_meip;
        vq.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prev_id;

        add_vec("single_src5",  bit_of(5), bit_of(5), prio_of(5, 3'd3), 3'd1, 8'd5, 1'b1);
        add_vec("tie_3_7",      bit_of(3) | bit_of(7), bit_of(3) | bit_of(7),
                prio_of(3, 3'd4) | prio_of(7, 3'd4), 3'd0, 8'd3, 1'b1);
        add_vec("prio7_up",     bit_of(3) | bit_of(7), bit_of(3) | bit_of(7),
                prio_of(3, 3'd4) | prio_of(7, 3'd6), 3'd0, 8'd7, 1'b1);
        add_vec("thr_6",        bit_of(3) | bit_of(7), bit_of(3) | bit_of(7),
                prio_of(3, 3'd4) | prio_of(7, 3'd6), 3'd6, 8'd0, 1'b0);
        add_vec("prio_zero",    bit_of(2), bit_of(2), prio_of(2, 3'd0), 3'd0, 8'd0, 1'b0);
        add_vec("ie_zero",      bit_of(6), '0, prio_of(6, 3'd7), 3'd0, 8'd0, 1'b0);
        add_vec("src0_pending", bit_of(0), bit_of(0), prio_of(0, 3'd7), 3'd0, 8'd0, 1'b0);
        add_vec("prio_eq_thr",  bit_of(10), bit_of(10), prio_of(10, 3'd3), 3'd3, 8'd0, 1'b0);
        add_vec("tie_1_31",     bit_of(1) | bit_of(31), bit_of(1) | bit_of(31),
                prio_of(1, 3'd7) | prio_of(31, 3'd7), 3'd0, 8'd1, 1'b1);
        add_vec("src31_only",   bit_of(31) | bit_of(4), bit_of(31) | bit_of(4),
                prio_of(31, 3'd7) | prio_of(4, 3'd5), 3'd5, 8'd31, 1'b1);

        rstn        = 1'b0;
        ext_irq     = '0;
        ip_r        = '0;
        ie_r        = '0;
        prio_r_1d   = '0;
        threshold_r = '0;
        claim_id    = '0;
        cmplt_id    = '0;
        acc         = '0;
`ifdef PLIC_EDGE_TRIG_EN
        src_edge    = '0;
`endif
        #12;
        check("reset_final_id", 64'(final_id), 64'd0);
        check("reset_meip", 64'(meip), 64'd0);
        check("reset_gate", 64'(plic_reg_gate), 64'd0);
        tick();
        rstn = 1'b1;
        tick();

        // Arbiter table: outputs hold until the next edge, then take the new value.
        prev_id = 8'd0;
        foreach (vq[k]) begin
            ip_r        = vq[k].ip;
            ie_r        = vq[k].ie;
            prio_r_1d   = vq[k].prio;
            threshold_r = vq[k].thr;
            #1;
            check({vq[k].name, "_hold"}, 64'(final_id), 64'(prev_id));
            tick();
            check({vq[k].name, "_id"}, 64'(final_id), 64'(vq[k].exp_id));
            check({vq[k].name, "_meip"}, 64'(meip), 64'(vq[k].exp_meip));
            prev_id = vq[k].exp_id;
        end
        ip_r = '0; ie_r = '0; prio_r_1d = '0; threshold_r = '0;
        tick();

        // Level source 5: gate at cycle +3, once.
        ext_irq = bit_of(5);
        tick(); check("gate5_c1", 64'(plic_reg_gate), 64'd0);
        tick(); check("gate5_c2", 64'(plic_reg_gate), 64'd0);
        tick(); check("gate5_c3", 64'(plic_reg_gate), 64'(bit_of(5)));
        ip_r = bit_of(5); ie_r = bit_of(5); prio_r_1d = prio_of(5, 3'd3); threshold_r = 3'd1;
        tick();
        check("gate5_single", 64'(plic_reg_gate), 64'd0);
        check("fb5_final_id", 64'(final_id), 64'd5);
        check("fb5_meip", 64'(meip), 64'd1);
        acc = '0; tick_acc(4);
        check("level_held_no_regate", 64'(acc), 64'd0);

        claim_id = 8'd5; tick(); claim_id = 8'd0;
        ip_r = '0;
        acc = '0; tick_acc(3);
        check("claimed_no_gate", 64'(acc), 64'd0);
        cmplt_id = 8'd5;
        tick(); check("cmpl5_edge", 64'(plic_reg_gate), 64'd0);
        tick(); check("reopen5", 64'(plic_reg_gate), 64'(bit_of(5)));
        tick(); check("reopen5_single", 64'(plic_reg_gate), 64'd0);
        claim_id = 8'd5; tick(); claim_id = 8'd0;
        acc = '0; tick_acc(4);
        check("cmpl_same_value_ignored", 64'(acc), 64'd0);
        cmplt_id = 8'd0; tick();
        cmplt_id = 8'd5; tick(); tick();
        check("reopen5_after_zero", 64'(plic_reg_gate), 64'(bit_of(5)));

        // Source 9: claim and completion land in the same cycle; claim wins.
        cmplt_id = 8'd0;
        ext_irq  = bit_of(5) | bit_of(9);
        tick(); tick(); tick();
        check("gate9_c3", 64'(plic_reg_gate), 64'(bit_of(9)));
        claim_id = 8'd9; cmplt_id = 8'd9;
        tick();
        claim_id = 8'd0;
        acc = '0; tick_acc(4);
        check("same_cycle_claim_wins", 64'(acc), 64'd0);
        cmplt_id = 8'd0; tick();
        cmplt_id = 8'd9; tick();
        check("cmpl9_edge", 64'(plic_reg_gate), 64'd0);
        tick();
        check("reopen9", 64'(plic_reg_gate), 64'(bit_of(9)));

        // Asynchronous reset while sources sit in PEND.
        ip_r = bit_of(5); ie_r = bit_of(5); prio_r_1d = prio_of(5, 3'd3); threshold_r = 3'd1;
        tick();
        check("pre_reset_final_id", 64'(final_id), 64'd5);
        #2 rstn = 1'b0;
        #1;
        check("midrst_final_id", 64'(final_id), 64'd0);
        check("midrst_meip", 64'(meip), 64'd0);
        check("midrst_gate", 64'(plic_reg_gate), 64'd0);
        ip_r = '0;
        tick(); tick();
        rstn = 1'b1;
        tick(); check("postrst_c1", 64'(plic_reg_gate), 64'd0);
        tick(); check("postrst_c2", 64'(plic_reg_gate), 64'd0);
        tick(); check("postrst_regate", 64'(plic_reg_gate), 64'(bit_of(5) | bit_of(9)));
        check("postrst_final_id", 64'(final_id), 64'd0);

`ifdef PLIC_EDGE_TRIG_EN
        // Edge source 4: two edges while CLAIMED merge into one deferred gate.
        src_edge = bit_of(4);
        ext_irq[4] = 1'b1; tick(); ext_irq[4] = 1'b0;
        tick(); check("edge4_c2", 64'(plic_reg_gate), 64'd0);
        tick(); check("edge4_c3", 64'(plic_reg_gate), 64'(bit_of(4)));
        claim_id = 8'd4; tick(); claim_id = 8'd0;
        acc = '0;
        for (int p = 0; p < 2; p++) begin
            ext_irq[4] = 1'b1; tick_acc(1); ext_irq[4] = 1'b0; tick_acc(3);
        end
        check("edge4_blocked", 64'(acc), 64'd0);
        cmplt_id = 8'd4;
        tick(); check("edge4_cmpl", 64'(plic_reg_gate), 64'd0);
        tick(); check("edge4_deferred", 64'(plic_reg_gate), 64'(bit_of(4)));
        acc = '0; tick_acc(5);
        check("edge4_merged_single", 64'(acc), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
